// File: rtl/store_align_buffer.sv
// Store alignment and write buffer: lane-replicates sb/sh/sw data, drops misaligned stores.
// Optional feature macro STORE_LOAD_HAZARD_EN adds a load/store word-address hazard check.
module store_align_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_type,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
`ifdef STORE_LOAD_HAZARD_EN
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
`endif
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [29:0]   addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [1:0]    k;
  logic [31:0]   al_wdata;
  logic [3:0]    al_be;
  logic          al_ok;
  logic          full;
  logic          accept;
  logic          enq;
  logic          pop;

  assign k        = st_addr[1:0];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign st_ready = ~full;
  assign accept   = st_valid & st_ready;
  assign enq      = accept & al_ok;
  assign mem_req  = ~empty;
  assign pop      = mem_req & mem_ack;

  // Lane replication, byte enables and alignment legality per store type
  always_comb begin
    al_wdata = st_data;
    al_be    = 4'b0000;
    al_ok    = 1'b0;
    unique case (st_type)
      2'b00: begin
        al_wdata = {4{st_data[7:0]}};
        al_be    = 4'b0001 << k;
        al_ok    = 1'b1;
      end
      2'b01: begin
        al_wdata = {2{st_data[15:0]}};
        al_be    = 4'b0011 << k;
        al_ok    = ~k[0];
      end
      2'b10: begin
        al_wdata = st_data;
        al_be    = 4'b1111;
        al_ok    = (k == 2'b00);
      end
      default: begin
        al_ok    = 1'b0;
      end
    endcase
  end

  // Pointer, occupancy and misalign-pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= accept & ~al_ok;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !pop)
        count <= count + 1'b1;
      else if (pop && !enq)
        count <= count - 1'b1;
    end
  end

  // Entry storage; contents are only visible while counted as valid
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr]  <= st_addr[31:2];
      wdata_q[wr_ptr] <= al_wdata;
      be_q[wr_ptr]    <= al_be;
    end
  end

  // Head entry drives memory; outputs idle at zero when empty
  always_comb begin
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    if (!empty) begin
      mem_addr  = {addr_q[rd_ptr], 2'b00};
      mem_wdata = wdata_q[rd_ptr];
      mem_be    = be_q[rd_ptr];
    end
  end

`ifdef STORE_LOAD_HAZARD_EN
  logic [AW-1:0] off;
  logic          unused_ld;

  assign unused_ld = ^ld_addr[1:0];

  // Word-address match against every occupied entry, head included
  always_comb begin
    ld_hazard = 1'b0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (addr_q[i] == ld_addr[31:2]))
        ld_hazard = 1'b1;
    end
  end
`endif

endmodule

// File: doc/store_align_buffer.md
STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning store-buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port st_valid  in  1  store request from core.
REQ-005 SHALL have port st_ready  out  1  buffer can accept a store.
REQ-006 SHALL have port st_addr  in  32  byte address of store.
REQ-007 SHALL have port st_data  in  32  unaligned store data (rs2), value in low bits.
REQ-008 SHALL have port st_type  in  2  00 sb, 01 sh, 10 sw, 11 reserved.
REQ-009 SHALL have port mem_req  out  1  write request to data memory.
REQ-010 SHALL have port mem_ack  in  1  memory accepted current write.
REQ-011 SHALL have port mem_addr  out  32  word-aligned address, bits[1:0] = 00.
REQ-012 SHALL have port mem_wdata  out  32  lane-replicated write data.
REQ-013 SHALL have port mem_be  out  4  byte enables, bit n = byte lane n (little endian).
REQ-014 SHALL have port misalign  out  1  one-cycle pulse: accepted store was dropped.
REQ-015 SHALL have port empty  out  1  no buffered stores.

Function
REQ-016 Alignment, k = st_addr[1:0]: sb -> wdata {4{st_data[7:0]}}, be 0001<<k; sh -> wdata {2{st_data[15:0]}}, be 0011<<k; sw -> wdata st_data, be 1111.
REQ-017 Misaligned (sh with k[0]=1; sw with k!=0) or st_type 11: handshake completes, nothing enqueued, misalign high the following cycle only.
REQ-018 st_ready = not full; depends only on registered state, never on st_valid or mem_ack.
REQ-019 Accepted aligned store enqueues {addr[31:2], wdata, be} at the tail on the same edge.
REQ-020 mem_req high iff buffer non-empty; mem_addr/mem_wdata/mem_be reflect the head entry.
REQ-021 While mem_req high and mem_ack low, mem_addr/mem_wdata/mem_be stay stable.
REQ-022 mem_req and mem_ack both high at an edge pops the head; the next entry is presented the following cycle.
REQ-023 mem_ack while mem_req low is ignored.
REQ-024 Store into an empty buffer: mem_req rises the cycle after acceptance (latency 1); no same-cycle bypass.
REQ-025 Full with simultaneous pop: st_ready stays low that cycle; no enqueue.
REQ-026 Non-full with simultaneous enqueue and pop: both occur; occupancy unchanged.
REQ-027 Stores issue to memory strictly in acceptance order; pointers wrap modulo DEPTH.
REQ-028 Idle values: mem_addr, mem_wdata, mem_be drive 0 when empty.

Reset
REQ-029 reset SHALL immediately clear pointers and occupancy; buffered stores are discarded, including a store mid-handshake.
REQ-030 Reset values: mem_req 0, mem_addr 0, mem_wdata 0, mem_be 0, misalign 0, empty 1, st_ready 1.
REQ-031 First acceptance is possible on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro STORE_LOAD_HAZARD_EN, when defined, SHALL add ld_addr in 32 and ld_hazard out 1.
REQ-033 ld_hazard is combinational: high iff any valid entry, head included, has word address equal to ld_addr[31:2].
REQ-034 Without STORE_LOAD_HAZARD_EN, both ports and all comparison logic are absent; all other behaviour is identical.

Verification
REQ-035 sb addr 0x103, data 0xAB, mem_ack tied 1 -> next cycle mem_req=1, mem_addr 0x100, mem_wdata 0xABABABAB, mem_be 1000.
REQ-036 sh addr 0x202, data 0x1234CAFE -> mem_wdata 0xCAFECAFE, mem_be 1100; sh addr 0x201 -> nothing enqueued, misalign pulses one cycle.
REQ-037 mem_ack held 0, DEPTH+1 sw stores offered -> st_ready low after DEPTH accepts; then ack every cycle -> DEPTH writes in order, addresses unchanged while unacked.
REQ-038 Full buffer, st_valid high, mem_ack high for one cycle -> pop occurs, no enqueue that cycle, store accepted the next cycle.
REQ-039 reset pulsed mid-cycle with 3 entries, mem_req high -> mem_req 0 and empty 1 without a clock edge; no further writes issue.
REQ-040 With STORE_LOAD_HAZARD_EN, buffered sw at 0x40 -> ld_addr 0x43 gives ld_hazard 1; ld_addr 0x44 gives 0; after ack, 0x43 gives 0.
